rng_unit_vn: RTL and testbench

//  Parametrised TRNG post-processing unit: samples NCH raw entropy channels, XOR-combines,

---
 rtl/rng_pkg.sv | 36 +++
 rtl/rng_vn_debias.sv | 31 +++
 rtl/rng_unit_vn.sv | 198 +++++++++++++++++++
 tb/tb_rng_unit_vn.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/rng_pkg.sv
// Shared types and PARAM field layout for the TRNG post-processing unit.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package rng_pkg;

  typedef enum logic [1:0] {
    MODE_RAW  = 2'd0,
    MODE_VN   = 2'd1,
    MODE_PACK = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_FAULT  = 2'd3
  } state_e;

  // PARAM word layout
  localparam int MODE_LSB = 0;
  localparam int MODE_W   = 2;
  localparam int DEC_LSB  = 8;
  localparam int RCT_LSB  = 16;
  localparam int MASK_LSB = 24;
  localparam int FIELD_W  = 8;

  // Encoding 3 is reserved and treated exactly like von-Neumann mode.
  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd0:    return MODE_RAW;
      2'd2:    return MODE_PACK;
      default: return MODE_VN;
    endcase
  endfunction

endpackage

// File: rtl/rng_vn_debias.sv
// Von-Neumann debiaser: pairs input bits, 01 -> 0, 10 -> 1, 00/11 dropped.
// Latency: combinational, out_valid in the same cycle as the second bit of a pair.
// Backpressure: none; every in_valid is consumed, clr discards a pending half-pair.
module rng_vn_debias (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic in_valid,
  input  logic in_bit,
  output logic out_valid,
  output logic out_bit
);

  logic half_q;
  logic first_q;

  // Hold the first bit of a pair; the pair restarts after every second bit.
  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      half_q  <= 1'b0;
      first_q <= 1'b0;
    end else if (in_valid) begin
      half_q <= ~half_q;
      if (!half_q) first_q <= in_bit;
    end
  end

  assign out_valid = in_valid && half_q && (first_q != in_bit);
  assign out_bit   = first_q;

endmodule

// File: rtl/rng_unit_vn.sv
// TRNG post-processing: channel combine, decimate, repetition-count test, optional VN debias and packing.
// Latency: the sample completing an output at cycle t gives a DATA_EN strobe at cycle t+1.
// Backpressure: none; one sample per cycle accepted, the consumer must take every DATA_EN.
module rng_unit_vn
  import rng_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int DW     = 16,
  parameter int WARMUP = 64,
  parameter int RCT_W  = 8
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           RNG_EN,
  input  logic [31:0]    PARAM,
  input  logic [NCH-1:0] RAW_IN,
  input  logic           RAW_VALID,
  output logic [DW-1:0]  DATA_OUT,
  output logic           DATA_EN,
  output logic           ERR
);

  localparam int WU_W = $clog2(WARMUP + 1);
  localparam int PK_W = $clog2(DW);

  state_e             state_q, state_d;
  logic [31:0]        param_q;
  logic               param_unused;
  mode_e              mode;
  logic [NCH-1:0]     mask;
  logic [FIELD_W-1:0] dec_dm1;
  logic [FIELD_W-1:0] rct_c;

  logic               active, leave, take, comb_bit;
  logic [FIELD_W-1:0] dec_cnt;
  logic               dec_acc;
  logic               d_vld, d_bit;
  logic [RCT_W-1:0]   rct_cnt, rct_nxt;
  logic               rct_bit, rct_trip;
  logic [WU_W-1:0]    wu_cnt;
  logic               wu_done, run_d;
  logic               vn_in, vn_vld, vn_bit;
  logic [PK_W-1:0]    pk_cnt;
  logic [DW-1:0]      pk_sh, pk_sh_nxt;
  logic               pk_full;
  logic               emit;
  logic [DW-1:0]      word;

  assign mode         = decode_mode(param_q[MODE_LSB +: MODE_W]);
  assign dec_dm1      = param_q[DEC_LSB +: FIELD_W];
  assign rct_c        = param_q[RCT_LSB +: FIELD_W];
  assign mask         = param_q[MASK_LSB +: NCH];
  assign param_unused = ^param_q;

  // A sample taken while RNG_EN is low is dropped: the unit is leaving for IDLE.
  assign active   = (state_q == ST_WARMUP) || (state_q == ST_RUN);
  assign leave    = active && !RNG_EN;
  assign take     = active && RNG_EN && RAW_VALID;
  assign comb_bit = ^(RAW_IN & mask);

  assign d_vld = take && (dec_cnt == dec_dm1);
  assign d_bit = dec_acc ^ comb_bit;

  // Repetition count including the current decimated bit; saturates at all-ones.
  always_comb begin
    rct_nxt = {{(RCT_W-1){1'b0}}, 1'b1};
    if (rct_cnt != '0 && d_bit == rct_bit)
      rct_nxt = (&rct_cnt) ? rct_cnt : rct_cnt + 1'b1;
  end

  assign rct_trip = d_vld && (rct_c != '0) && (32'(rct_nxt) >= 32'(rct_c));
  assign wu_done  = d_vld && !rct_trip && (state_q == ST_WARMUP) &&
                    (wu_cnt == WU_W'(WARMUP - 1));
  assign run_d    = d_vld && !rct_trip && (state_q == ST_RUN);
  assign vn_in    = run_d && (mode != MODE_RAW);

  rng_vn_debias u_vn (
    .CLK       (CLK),
    .RST       (RST),
    .clr       (leave),
    .in_valid  (vn_in),
    .in_bit    (d_bit),
    .out_valid (vn_vld),
    .out_bit   (vn_bit)
  );

  // Newest bit enters at the top so the oldest lands in bit 0 of a full word.
  assign pk_sh_nxt = {vn_bit, pk_sh[DW-1:1]};
  assign pk_full   = (pk_cnt == PK_W'(DW - 1));

  // Select what reaches DATA_OUT for the current mode.
  always_comb begin
    emit = 1'b0;
    word = '0;
    case (mode)
      MODE_RAW: begin
        emit = run_d;
        word = {{(DW-1){1'b0}}, d_bit};
      end
      MODE_PACK: begin
        emit = vn_vld && pk_full;
        word = pk_sh_nxt;
      end
      default: begin
        emit = vn_vld;
        word = {{(DW-1){1'b0}}, vn_bit};
      end
    endcase
  end

  // Next-state logic; FAULT is left only through RST.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (RNG_EN) state_d = ST_WARMUP;
      ST_WARMUP: begin
        if (!RNG_EN)       state_d = ST_IDLE;
        else if (rct_trip) state_d = ST_FAULT;
        else if (wu_done)  state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!RNG_EN)       state_d = ST_IDLE;
        else if (rct_trip) state_d = ST_FAULT;
      end
      default:             state_d = ST_FAULT;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Configuration is frozen for the whole enable session.
  always_ff @(posedge CLK) begin
    if (RST)                                 param_q <= '0;
    else if (state_q == ST_IDLE && RNG_EN)   param_q <= PARAM;
  end

  // Decimator: XOR of D consecutive combined bits.
  always_ff @(posedge CLK) begin
    if (RST || leave) begin
      dec_cnt <= '0;
      dec_acc <= 1'b0;
    end else if (take) begin
      if (d_vld) begin
        dec_cnt <= '0;
        dec_acc <= 1'b0;
      end else begin
        dec_cnt <= dec_cnt + 1'b1;
        dec_acc <= d_bit;
      end
    end
  end

  // Repetition-count state, kept across WARMUP->RUN.
  always_ff @(posedge CLK) begin
    if (RST || leave) begin
      rct_cnt <= '0;
      rct_bit <= 1'b0;
    end else if (d_vld) begin
      rct_cnt <= rct_nxt;
      rct_bit <= d_bit;
    end
  end

  // Count decimated bits discarded during warm-up.
  always_ff @(posedge CLK) begin
    if (RST || leave)                        wu_cnt <= '0;
    else if (d_vld && state_q == ST_WARMUP)  wu_cnt <= wu_cnt + 1'b1;
  end

  // Packer shift register and fill count.
  always_ff @(posedge CLK) begin
    if (RST || leave) begin
      pk_cnt <= '0;
      pk_sh  <= '0;
    end else if (vn_vld && mode == MODE_PACK) begin
      pk_cnt <= pk_full ? '0 : pk_cnt + 1'b1;
      pk_sh  <= pk_sh_nxt;
    end
  end

  // Output registers; DATA_OUT holds its last word between strobes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      DATA_OUT <= '0;
      DATA_EN  <= 1'b0;
    end else begin
      DATA_EN <= emit;
      if (emit) DATA_OUT <= word;
    end
  end

  assign ERR = (state_q == ST_FAULT);

endmodule

// File: tb/tb_rng_unit_vn.sv
// Directed bench for rng_unit_vn with hand-computed expected outputs.
// Latency: checks the t+1 strobe timing sample by sample.
// Backpressure: none exercised; the bench accepts every strobe.
module tb_rng_unit_vn;
  import rng_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        RNG_EN;
  logic [31:0] PARAM;
  logic [3:0]  RAW_IN;
  logic        RAW_VALID;
  logic [15:0] DATA_OUT;
  logic        DATA_EN;
  logic        ERR;

  int vec_cnt = 0;
  int err_cnt = 0;

  rng_unit_vn #(.NCH(4), .DW(16), .WARMUP(64), .RCT_W(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RNG_EN    (RNG_EN),
    .PARAM     (PARAM),
    .RAW_IN    (RAW_IN),
    .RAW_VALID (RAW_VALID),
    .DATA_OUT  (DATA_OUT),
    .DATA_EN   (DATA_EN),
    .ERR       (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mkp(input logic [7:0] mask, input logic [7:0] c,
                                      input logic [7:0] dm1, input logic [1:0] mode);
    return {mask, c, dm1, 6'd0, mode};
  endfunction

  // Drive one cycle of inputs, then sample just after the capturing edge.
  task automatic step(input logic en, input logic vld, input logic [3:0] raw);
    RNG_EN    = en;
    RAW_VALID = vld;
    RAW_IN    = raw;
    @(posedge CLK);
    #1;
  endtask

  // Feed n alternating samples (1,0,1,..) on channel 0; return strobes seen.
  task automatic feed_alt(input int n, output int strobes);
    strobes = 0;
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b1, (i % 2 == 0) ? 4'h1 : 4'h0);
      if (DATA_EN) strobes++;
    end
  endtask

  int n_en;
  int vn_seq [8] = '{0, 1, 1, 1, 1, 0, 0, 0};
  int vn_en  [8] = '{0, 1, 0, 0, 0, 1, 0, 0};

  initial begin
    RST = 1'b1; RNG_EN = 1'b0; PARAM = '0; RAW_IN = '0; RAW_VALID = 1'b0;
    step(1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b0, 4'h0);
    RST = 1'b0;
    chk("rst_en",    32'(DATA_EN), 32'd0);
    chk("rst_err",   32'(ERR), 32'd0);
    chk("rst_out",   32'(DATA_OUT), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));

    // RAW mode, D=1, mask=1: 64 warm-up bits dropped, then 1,0,1,0,1.
    PARAM = mkp(8'h01, 8'd0, 8'd0, 2'd0);
    step(1'b1, 1'b0, 4'h0);
    chk("raw_warm_state", 32'(dut.state_q), 32'(ST_WARMUP));
    feed_alt(64, n_en);
    chk("raw_warm_silent", 32'(n_en), 32'd0);
    for (int i = 64; i < 69; i++) begin
      step(1'b1, 1'b1, (i % 2 == 0) ? 4'h1 : 4'h0);
      chk("raw_en",  32'(DATA_EN), 32'd1);
      chk("raw_bit", 32'(DATA_OUT), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    step(1'b0, 1'b0, 4'h0);
    chk("raw_off_state", 32'(dut.state_q), 32'(ST_IDLE));

    // VN mode: d = 0,1,1,1,1,0,0,0 -> strobes carrying 0 then 1.
    PARAM = mkp(8'h01, 8'd0, 8'd0, 2'd1);
    step(1'b1, 1'b0, 4'h0);
    feed_alt(64, n_en);
    chk("vn_warm_silent", 32'(n_en), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, {3'b000, vn_seq[i][0]});
      chk("vn_en", 32'(DATA_EN), 32'(vn_en[i]));
      if (i == 1) chk("vn_bit0", 32'(DATA_OUT), 32'd0);
      if (i == 5) chk("vn_bit1", 32'(DATA_OUT), 32'd1);
    end
    step(1'b0, 1'b0, 4'h0);

    // PACK mode: VN bits 1,0,..,0 -> one word 16'h0001.
    PARAM = mkp(8'h01, 8'd0, 8'd0, 2'd2);
    step(1'b1, 1'b0, 4'h0);
    feed_alt(64, n_en);
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1'b1, (k == 0) ? 4'h1 : 4'h0);
      step(1'b1, 1'b1, (k == 0) ? 4'h0 : 4'h1);
      chk("pack_en", 32'(DATA_EN), (k == 15) ? 32'd1 : 32'd0);
    end
    chk("pack_word", 32'(DATA_OUT), 32'h0001);
    // Ten more VN bits, then reset in the middle of the word.
    n_en = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b1, 4'h1);
      if (DATA_EN) n_en++;
      step(1'b1, 1'b1, 4'h0);
      if (DATA_EN) n_en++;
    end
    chk("pack_partial_silent", 32'(n_en), 32'd0);
    RST = 1'b1;
    step(1'b1, 1'b1, 4'h1);
    RST = 1'b0;
    chk("midrst_en",    32'(DATA_EN), 32'd0);
    chk("midrst_err",   32'(ERR), 32'd0);
    chk("midrst_out",   32'(DATA_OUT), 32'd0);
    chk("midrst_state", 32'(dut.state_q), 32'(ST_IDLE));
    step(1'b0, 1'b0, 4'h0);

    // RNG_EN falls on a completing sample; re-enable with D=2.
    PARAM = mkp(8'h01, 8'd0, 8'd0, 2'd0);
    step(1'b1, 1'b0, 4'h0);
    feed_alt(64, n_en);
    for (int i = 64; i < 67; i++) step(1'b1, 1'b1, (i % 2 == 0) ? 4'h1 : 4'h0);
    chk("fall_pre_out", 32'(DATA_OUT), 32'd1);
    step(1'b0, 1'b1, 4'h0);
    chk("fall_en",    32'(DATA_EN), 32'd0);
    chk("fall_hold",  32'(DATA_OUT), 32'd1);
    chk("fall_state", 32'(dut.state_q), 32'(ST_IDLE));
    PARAM = mkp(8'h01, 8'd0, 8'd1, 2'd0);
    step(1'b1, 1'b0, 4'h0);
    chk("reen_state", 32'(dut.state_q), 32'(ST_WARMUP));
    PARAM = mkp(8'h01, 8'd0, 8'd0, 2'd1);
    feed_alt(128, n_en);
    chk("reen_warm_silent", 32'(n_en), 32'd0);
    step(1'b1, 1'b1, 4'h1);
    chk("d2_half_en", 32'(DATA_EN), 32'd0);
    step(1'b1, 1'b1, 4'h0);
    chk("d2_en_a",  32'(DATA_EN), 32'd1);
    chk("d2_bit_a", 32'(DATA_OUT), 32'd1);
    step(1'b1, 1'b1, 4'h1);
    step(1'b1, 1'b1, 4'h1);
    chk("d2_en_b",  32'(DATA_EN), 32'd1);
    chk("d2_bit_b", 32'(DATA_OUT), 32'd0);
    step(1'b0, 1'b0, 4'h0);

    // Repetition-count fault: C=5, input stuck at 1.
    PARAM = mkp(8'h01, 8'd5, 8'd0, 2'd0);
    step(1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 4'h1);
      chk("rct_err", 32'(ERR), (i == 4) ? 32'd1 : 32'd0);
      chk("rct_en",  32'(DATA_EN), 32'd0);
    end
    step(1'b0, 1'b1, 4'h1);
    step(1'b1, 1'b1, 4'h1);
    step(1'b1, 1'b1, 4'h0);
    chk("fault_sticky", 32'(ERR), 32'd1);
    chk("fault_en",     32'(DATA_EN), 32'd0);
    chk("fault_state",  32'(dut.state_q), 32'(ST_FAULT));
    RST = 1'b1;
    step(1'b0, 1'b0, 4'h0);
    RST = 1'b0;
    chk("fault_rst_err", 32'(ERR), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
